// File: rtl/id_decode_queue.sv
// Decode stage for the rv32i pipeline: DEPTH-entry instruction queue, head decode,
// load-use hazard detection and a registered valid/ready packet towards EX.
module id_decode_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [31:0]      if_inst,
    input  logic             flush,
    input  logic             ex_load_valid,
    input  logic [4:0]       ex_load_rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    input  logic [XLEN-1:0]  reg_a,
    input  logic [XLEN-1:0]  reg_b,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_imm,
    output logic [XLEN-1:0]  id_rs1_out,
    output logic [XLEN-1:0]  id_rs2_out,
    output logic [6:0]       id_opcode,
    output logic [2:0]       id_funct3,
    output logic [6:0]       id_funct7,
    output logic [4:0]       id_rd,
    output logic [4:0]       id_rs1,
    output logic [4:0]       id_rs2,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] occupancy
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic [XLEN-1:0]  r_pc_q   [DEPTH];
    logic [31:0]      r_inst_q [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;

    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_inst;
    logic [6:0]  w_op;
    logic [31:0] w_imm32;
    logic        w_use1;
    logic        w_use2;

    // Circular pointer advance; wraps at DEPTH for any queue depth.
    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_empty   = (r_cnt == '0);
    assign if_ready  = (r_cnt < CNT_W'(DEPTH));
    assign occupancy = r_cnt;
    assign w_inst    = r_inst_q[r_rptr];
    assign w_op      = w_inst[6:0];
    assign rs1       = w_inst[19:15];
    assign rs2       = w_inst[24:20];

    // Format-selected immediate of the head instruction.
    always_comb begin
        w_imm32 = 32'd0;
        w_use1  = 1'b1;
        w_use2  = 1'b0;
        case (w_op)
            OP_LOAD, OP_IMM, OP_JALR: w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
            OP_STORE: begin
                w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
                w_use2  = 1'b1;
            end
            OP_BR: begin
                w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
                w_use2  = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                w_imm32 = {w_inst[31:12], 12'd0};
                w_use1  = 1'b0;
            end
            OP_JAL: begin
                w_imm32 = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
                w_use1  = 1'b0;
            end
            OP_REG:  w_use2 = 1'b1;
            default: w_imm32 = 32'd0;
        endcase
    end

    assign hazard_stall = !w_empty && ex_load_valid && (ex_load_rd != 5'd0) &&
                          ((w_use1 && (ex_load_rd == rs1)) || (w_use2 && (ex_load_rd == rs2)));

    assign w_pop  = !w_empty && !hazard_stall && (!id_valid || id_ready) && !flush;
    assign w_push = if_valid && if_ready && !flush;

    // Queue storage carries no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_q[r_wptr]   <= if_pc;
            r_inst_q[r_wptr] <= if_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= f_inc(r_wptr);
            if (w_pop)  r_rptr <= f_inc(r_rptr);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
            else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // ID/EX packet register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_imm     <= '0;
            id_rs1_out <= '0;
            id_rs2_out <= '0;
            id_opcode  <= '0;
            id_funct3  <= '0;
            id_funct7  <= '0;
            id_rd      <= '0;
            id_rs1     <= '0;
            id_rs2     <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (w_pop) begin
            id_valid   <= 1'b1;
            id_pc      <= r_pc_q[r_rptr];
            id_imm     <= XLEN'($signed(w_imm32));
            id_rs1_out <= reg_a;
            id_rs2_out <= reg_b;
            id_opcode  <= w_op;
            id_funct3  <= w_inst[14:12];
            id_funct7  <= w_inst[31:25];
            id_rd      <= w_inst[11:7];
            id_rs1     <= rs1;
            id_rs2     <= rs2;
        end else if (id_valid && id_ready) begin
            id_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_decode_queue.sv
// Bench for id_decode_queue: DEPTH=2 and DEPTH=3 instances on shared stimulus,
// directed scenarios plus random traffic against a queue-based reference model.
module tb_id_decode_queue;
    logic clk;
    logic rst;
    logic if_valid, flush, ex_load_valid, id_ready;
    logic [31:0] if_pc, if_inst;
    logic [4:0]  ex_load_rd;

    logic        if_ready_o [2];
    logic [4:0]  rs1_o [2];
    logic [4:0]  rs2_o [2];
    logic [31:0] reg_a_w [2];
    logic [31:0] reg_b_w [2];
    logic        id_valid_o [2];
    logic [31:0] id_pc_o [2];
    logic [31:0] id_imm_o [2];
    logic [31:0] id_a_o [2];
    logic [31:0] id_b_o [2];
    logic [6:0]  id_opc_o [2];
    logic [2:0]  id_f3_o [2];
    logic [6:0]  id_f7_o [2];
    logic [4:0]  id_rd_o [2];
    logic [4:0]  id_rs1_o [2];
    logic [4:0]  id_rs2_o [2];
    logic        hz_o [2];
    logic [1:0]  occ_o [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rega(input logic [4:0] r);
        return 32'hA500_0000 + 32'(r) * 32'h0001_0203;
    endfunction
    function automatic logic [31:0] regb(input logic [4:0] r);
        return ~rega(r) ^ 32'h0000_005A;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign reg_a_w[g] = rega(rs1_o[g]);
        assign reg_b_w[g] = regb(rs2_o[g]);
        id_decode_queue #(.XLEN(32), .DEPTH(2 + g)) u_dut (
            .clk(clk), .rst(rst),
            .if_valid(if_valid), .if_ready(if_ready_o[g]), .if_pc(if_pc), .if_inst(if_inst),
            .flush(flush), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
            .rs1(rs1_o[g]), .rs2(rs2_o[g]), .reg_a(reg_a_w[g]), .reg_b(reg_b_w[g]),
            .id_valid(id_valid_o[g]), .id_ready(id_ready),
            .id_pc(id_pc_o[g]), .id_imm(id_imm_o[g]), .id_rs1_out(id_a_o[g]), .id_rs2_out(id_b_o[g]),
            .id_opcode(id_opc_o[g]), .id_funct3(id_f3_o[g]), .id_funct7(id_f7_o[g]),
            .id_rd(id_rd_o[g]), .id_rs1(id_rs1_o[g]), .id_rs2(id_rs2_o[g]),
            .hazard_stall(hz_o[g]), .occupancy(occ_o[g])
        );
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } pkt_t;

    ent_t mq0[$];
    ent_t mq1[$];
    pkt_t mpkt [2];
    logic mval [2];
    logic e_rdy [2];
    logic e_hz [2];
    logic [1:0] e_occ [2];
    logic s_rdy [2];
    logic s_hz [2];
    logic [1:0] s_occ [2];
    int tests;
    int failed;

    // Reference decode written directly from the ISA field layout.
    function automatic logic [31:0] f_imm(input logic [31:0] i);
        case (i[6:0])
            7'h03, 7'h13, 7'h67: return {{20{i[31]}}, i[31:20]};
            7'h23: return {{20{i[31]}}, i[31:25], i[11:7]};
            7'h63: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'h37, 7'h17: return {i[31:12], 12'd0};
            7'h6F: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction
    function automatic logic uses1(input logic [6:0] op);
        return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    endfunction
    function automatic logic uses2(input logic [6:0] op);
        return (op == 7'h33 || op == 7'h23 || op == 7'h63);
    endfunction

    function automatic int msize(input int d);
        return (d == 0) ? mq0.size() : mq1.size();
    endfunction
    function automatic ent_t mfront(input int d);
        return (d == 0) ? mq0[0] : mq1[0];
    endfunction
    task automatic mpop(input int d);
        if (d == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
    endtask
    task automatic mpush(input int d, input ent_t e);
        if (d == 0) mq0.push_back(e); else mq1.push_back(e);
    endtask
    task automatic mreset();
        mq0.delete();
        mq1.delete();
        for (int d = 0; d < 2; d++) begin
            mval[d] = 1'b0;
            mpkt[d] = '0;
        end
    endtask

    function automatic pkt_t dut_pkt(input int d);
        pkt_t p;
        p = '{pc: id_pc_o[d], imm: id_imm_o[d], a: id_a_o[d], b: id_b_o[d], opc: id_opc_o[d],
              f3: id_f3_o[d], f7: id_f7_o[d], rd: id_rd_o[d], rs1: id_rs1_o[d], rs2: id_rs2_o[d]};
        return p;
    endfunction

    // One clock of the reference: comb expectations from current inputs, then state update.
    task automatic model_eval(input int d);
        ent_t h;
        pkt_t p;
        int   n;
        logic adv;
        n = msize(d);
        e_occ[d] = 2'(n);
        e_rdy[d] = (n < 2 + d);
        e_hz[d]  = 1'b0;
        h = '0;
        if (n > 0) begin
            h = mfront(d);
            e_hz[d] = ex_load_valid && (ex_load_rd != 5'd0) &&
                      ((uses1(h.inst[6:0]) && ex_load_rd == h.inst[19:15]) ||
                       (uses2(h.inst[6:0]) && ex_load_rd == h.inst[24:20]));
        end
        adv = (n > 0) && !e_hz[d] && (!mval[d] || id_ready) && !flush;
        if (flush) begin
            if (d == 0) mq0.delete(); else mq1.delete();
            mval[d] = 1'b0;
        end else begin
            if (adv) begin
                p.pc  = h.pc;
                p.imm = f_imm(h.inst);
                p.a   = rega(h.inst[19:15]);
                p.b   = regb(h.inst[24:20]);
                p.opc = h.inst[6:0];
                p.f3  = h.inst[14:12];
                p.f7  = h.inst[31:25];
                p.rd  = h.inst[11:7];
                p.rs1 = h.inst[19:15];
                p.rs2 = h.inst[24:20];
                mpkt[d] = p;
                mval[d] = 1'b1;
                mpop(d);
            end else if (mval[d] && id_ready) begin
                mval[d] = 1'b0;
            end
            if (if_valid && e_rdy[d]) mpush(d, '{pc: if_pc, inst: if_inst});
        end
    endtask

    task automatic tick();
        #1;
        for (int d = 0; d < 2; d++) begin
            s_rdy[d] = if_ready_o[d];
            s_hz[d]  = hz_o[d];
            s_occ[d] = occ_o[d];
            model_eval(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid = 1'b0; flush = 1'b0; ex_load_valid = 1'b0; ex_load_rd = 5'd0;
        id_ready = 1'b1; if_pc = 32'd0; if_inst = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (occ_o[d] !== 2'd0 || id_valid_o[d] !== 1'b0 || id_pc_o[d] !== 32'd0 ||
                id_imm_o[d] !== 32'd0 || id_opc_o[d] !== 7'd0 || id_rd_o[d] !== 5'd0) begin
                failed++;
                $display("FAIL reset_state d%0d occ=%0d valid=%b pc=%h imm=%h required all zero",
                         d, occ_o[d], id_valid_o[d], id_pc_o[d], id_imm_o[d]);
            end
        end
        mreset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (if_ready_o[d] !== 1'b1) begin
                failed++;
                $display("FAIL reset_if_ready d%0d got %b required 1", d, if_ready_o[d]);
            end
        end
    endtask

    task automatic test_addi();
        if_valid = 1'b1; if_pc = 32'h60; if_inst = 32'hFFF1_0093; id_ready = 1'b1;
        tick();
        if_valid = 1'b0;
        tests++;
        if (id_valid_o[0] !== 1'b0) begin
            failed++;
            $display("FAIL addi_latency got id_valid=%b required 0 after one edge", id_valid_o[0]);
        end
        tick();
        tests++;
        if (id_valid_o[0] !== 1'b1 || id_opc_o[0] !== 7'h13 || id_rd_o[0] !== 5'd1 ||
            id_rs1_o[0] !== 5'd2 || id_imm_o[0] !== 32'hFFFF_FFFF || id_pc_o[0] !== 32'h60) begin
            failed++;
            $display("FAIL addi_packet got v=%b opc=%h rd=%0d rs1=%0d imm=%h pc=%h required 1 13 1 2 ffffffff 60",
                     id_valid_o[0], id_opc_o[0], id_rd_o[0], id_rs1_o[0], id_imm_o[0], id_pc_o[0]);
        end
        tick();
    endtask

    task automatic test_lui();
        ex_load_valid = 1'b1; ex_load_rd = 5'd0;
        if_valid = 1'b1; if_pc = 32'h64; if_inst = 32'h1234_53B7;
        tick();
        if_valid = 1'b0;
        tests++;
        if (hz_o[0] !== 1'b0) begin
            failed++;
            $display("FAIL lui_no_hazard got %b required 0", hz_o[0]);
        end
        tick();
        tests++;
        if (id_valid_o[0] !== 1'b1 || id_imm_o[0] !== 32'h1234_5000 || id_opc_o[0] !== 7'h37) begin
            failed++;
            $display("FAIL lui_packet got v=%b imm=%h opc=%h required 1 12345000 37",
                     id_valid_o[0], id_imm_o[0], id_opc_o[0]);
        end
        ex_load_valid = 1'b0;
        tick();
    endtask

    task automatic test_hazard();
        ex_load_valid = 1'b1; ex_load_rd = 5'd5;
        if_valid = 1'b1; if_pc = 32'h68; if_inst = 32'h0052_8333;
        tick();
        if_valid = 1'b0;
        tests++;
        if (hz_o[0] !== 1'b1 || occ_o[0] !== 2'd1) begin
            failed++;
            $display("FAIL hazard_detect got hz=%b occ=%0d required 1 1", hz_o[0], occ_o[0]);
        end
        tick();
        tests++;
        if (id_valid_o[0] !== 1'b0 || occ_o[0] !== 2'd1) begin
            failed++;
            $display("FAIL hazard_stall_hold got v=%b occ=%0d required 0 1", id_valid_o[0], occ_o[0]);
        end
        ex_load_valid = 1'b0;
        tick();
        tests++;
        if (id_valid_o[0] !== 1'b1 || id_rd_o[0] !== 5'd6 || id_a_o[0] !== rega(5'd5) || id_b_o[0] !== regb(5'd5)) begin
            failed++;
            $display("FAIL hazard_release got v=%b rd=%0d a=%h b=%h required 1 6 %h %h",
                     id_valid_o[0], id_rd_o[0], id_a_o[0], id_b_o[0], rega(5'd5), regb(5'd5));
        end
        tick();
    endtask

    task automatic fill3(input logic [31:0] base);
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if_valid = 1'b1;
            if_pc    = base + 32'(4 * k);
            if_inst  = 32'h0000_0093 | (32'(k + 1) << 7);
            tick();
        end
        if_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        fill3(32'h100);
        tests++;
        if (occ_o[0] !== 2'd2 || if_ready_o[0] !== 1'b0 || id_valid_o[0] !== 1'b1 || id_pc_o[0] !== 32'h100) begin
            failed++;
            $display("FAIL bp_full got occ=%0d rdy=%b v=%b pc=%h required 2 0 1 100",
                     occ_o[0], if_ready_o[0], id_valid_o[0], id_pc_o[0]);
        end
        id_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            tick();
            tests++;
            if (id_valid_o[0] !== 1'b1 || id_pc_o[0] !== 32'h100 + 32'(4 * k)) begin
                failed++;
                $display("FAIL bp_drain%0d got v=%b pc=%h required 1 %h",
                         k, id_valid_o[0], id_pc_o[0], 32'h100 + 32'(4 * k));
            end
        end
        tick();
        tests++;
        if (id_valid_o[0] !== 1'b0) begin
            failed++;
            $display("FAIL bp_empty got v=%b required 0", id_valid_o[0]);
        end
    endtask

    task automatic test_flush();
        fill3(32'h200);
        flush = 1'b1; if_valid = 1'b1; if_pc = 32'h300; if_inst = 32'h0000_0013;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (occ_o[d] !== 2'd0 || id_valid_o[d] !== 1'b0) begin
                failed++;
                $display("FAIL flush_clear d%0d got occ=%0d v=%b required 0 0", d, occ_o[d], id_valid_o[d]);
            end
        end
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (id_valid_o[0] !== 1'b0 || id_valid_o[1] !== 1'b0) begin
                failed++;
                $display("FAIL flush_dropped c%0d got v0=%b v1=%b pc0=%h required both 0",
                         k, id_valid_o[0], id_valid_o[1], id_pc_o[0]);
            end
        end
    endtask

    task automatic test_wrap();
        id_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if_valid = 1'b1;
            if_pc    = 32'h400 + 32'(4 * k);
            if_inst  = 32'h0000_0013 | (32'(k + 1) << 7);
            tick();
            if (k >= 1) begin
                tests++;
                if (occ_o[1] !== 2'd1 || id_valid_o[1] !== 1'b1 || id_pc_o[1] !== 32'h400 + 32'(4 * (k - 1))) begin
                    failed++;
                    $display("FAIL wrap_c%0d got occ=%0d v=%b pc=%h required 1 1 %h",
                             k, occ_o[1], id_valid_o[1], id_pc_o[1], 32'h400 + 32'(4 * (k - 1)));
                end
            end
        end
        if_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_random(input int ncyc);
        logic [6:0] ops [11];
        logic [31:0] w;
        ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73};
        for (int c = 0; c < ncyc; c++) begin
            w = $urandom;
            w[6:0]   = ops[$urandom_range(0, 10)];
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            if_inst       = w;
            if_pc         = $urandom & 32'hFFFF_FFFC;
            if_valid      = ($urandom_range(0, 9) < 7);
            id_ready      = ($urandom_range(0, 9) < 6);
            flush         = ($urandom_range(0, 19) == 0);
            ex_load_valid = ($urandom_range(0, 9) < 3);
            ex_load_rd    = 5'($urandom_range(0, 7));
            tick();
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (s_rdy[d] !== e_rdy[d] || s_hz[d] !== e_hz[d] || s_occ[d] !== e_occ[d]) begin
                    failed++;
                    $display("FAIL rand_comb d%0d c%0d got rdy=%b hz=%b occ=%0d required %b %b %0d",
                             d, c, s_rdy[d], s_hz[d], s_occ[d], e_rdy[d], e_hz[d], e_occ[d]);
                end
                tests++;
                if (id_valid_o[d] !== mval[d] || (mval[d] && dut_pkt(d) !== mpkt[d])) begin
                    failed++;
                    $display("FAIL rand_pkt d%0d c%0d got v=%b pkt=%h required v=%b pkt=%h",
                             d, c, id_valid_o[d], dut_pkt(d), mval[d], mpkt[d]);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (occ_o[d] !== 2'd0 || id_valid_o[d] !== 1'b0 || id_pc_o[d] !== 32'd0 || id_imm_o[d] !== 32'd0) begin
                failed++;
                $display("FAIL reset_mid d%0d got occ=%0d v=%b pc=%h imm=%h required all zero",
                         d, occ_o[d], id_valid_o[d], id_pc_o[d], id_imm_o[d]);
            end
        end
        mreset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_addi();
        test_lui();
        test_hazard();
        test_backpressure();
        test_flush();
        test_wrap();
        test_random(400);
        test_reset_mid();
        test_random(100);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
